// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_if
//  Description : Fetch-stage bundle: execute redirect, instruction-memory
//                AR/R read channel, decode-side stream and fault pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_if;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        fault;

    // Fetch stage side
    modport master (
        input  redirect, target, arready, rdata, rresp, rvalid, tready,
        output araddr, arvalid, rready, tdata, tvalid, fault
    );

    // Environment side (execute, memory, decode)
    modport slave (
        output redirect, target, arready, rdata, rresp, rvalid, tready,
        input  araddr, arvalid, rready, tdata, tvalid, fault
    );
endinterface
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
//  Module      : fetch
//  Description : Instruction fetch stage. Holds the PC, issues word reads,
//                returns {pc, ir} pairs to decode and squashes wrong-path
//                fetches on a redirect. Credits bound outstanding reads plus
//                buffered results to DEPTH, so the R channel never stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 2
) (
    input  logic    aclk,
    input  logic    aresetn,
    fetch_if.master fi
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] C_DEPTH = (CW+1)'(DEPTH);

    logic [31:0] pc_q, pc_d;
    logic        run_q;
    logic        ar_hold_q, ar_hold_d;
    logic        ar_stale_q, ar_stale_d;
    logic [31:0] ar_addr_q;
    logic [31:0] afifo_q [DEPTH];
    logic [AW-1:0] af_wp_q, af_rp_q;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [63:0] obuf_q [DEPTH];
    logic [AW-1:0] ob_wp_q, ob_wp_d, ob_rp_q, ob_rp_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] drop_q, drop_d;
    logic        fault_q, fault_d;

    logic        w_pop, w_push, w_credit_ok;
    logic        w_arvalid, w_ar_hs, w_r_hs;
    logic [31:0] w_araddr, w_head;
    logic [63:0] w_entry;
    logic        w_unused;

    // The slot freed by a same-cycle pop is reusable, giving 1 fetch/cycle.
    assign w_pop       = (occ_q != '0) & fi.tready;
    assign w_credit_ok = (({1'b0, inflight_q} + {1'b0, occ_q})
                          - {{CW{1'b0}}, w_pop}) < C_DEPTH;
    // A held request keeps arvalid/araddr stable regardless of redirect.
    assign w_arvalid   = ar_hold_q | (run_q & ~fi.redirect & w_credit_ok);
    assign w_araddr    = ar_hold_q ? ar_addr_q : pc_q;
    assign w_ar_hs     = w_arvalid & fi.arready;
    assign w_r_hs      = fi.rvalid & run_q;
    assign w_head      = afifo_q[af_rp_q];
    // Beats in a redirect cycle or owed to the drop count never enter the buffer.
    assign w_push      = w_r_hs & ~fi.redirect & (drop_q == '0);
    assign w_entry     = {w_head, (fi.rresp == 2'b00) ? fi.rdata : 32'h0000_0000};
    assign w_unused    = ^fi.target[1:0];

    // Next-state computation for PC, request hold, counters and buffer pointers.
    always_comb begin
        pc_d       = pc_q;
        ar_hold_d  = w_arvalid & ~fi.arready;
        ar_stale_d = ar_hold_d & (ar_stale_q | fi.redirect);
        inflight_d = inflight_q + CW'(w_ar_hs) - CW'(w_r_hs);
        occ_d      = occ_q + CW'(w_push) - CW'(w_pop);
        ob_wp_d    = ob_wp_q + AW'(w_push);
        ob_rp_d    = ob_rp_q + AW'(w_pop);
        drop_d     = drop_q;
        fault_d    = w_push & (fi.rresp != 2'b00);
        if (fi.redirect) begin
            pc_d    = {fi.target[31:2], 2'b00};
            occ_d   = '0;
            ob_wp_d = '0;
            ob_rp_d = '0;
            // Everything still owed a response after this cycle is wrong-path.
            drop_d  = inflight_q + CW'(w_arvalid) - CW'(w_r_hs);
        end else begin
            // A held request issued before a redirect must not advance the new PC.
            if (w_ar_hs && !(ar_hold_q && ar_stale_q)) begin
                pc_d = pc_q + 32'd4;
            end
            if (w_r_hs && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    // Control and counter registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pc_q       <= RESET_ADDR;
            run_q      <= 1'b0;
            ar_hold_q  <= 1'b0;
            ar_stale_q <= 1'b0;
            ar_addr_q  <= '0;
            inflight_q <= '0;
            occ_q      <= '0;
            ob_wp_q    <= '0;
            ob_rp_q    <= '0;
            drop_q     <= '0;
            fault_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            run_q      <= 1'b1;
            ar_hold_q  <= ar_hold_d;
            ar_stale_q <= ar_stale_d;
            ar_addr_q  <= w_araddr;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            ob_wp_q    <= ob_wp_d;
            ob_rp_q    <= ob_rp_d;
            drop_q     <= drop_d;
            fault_q    <= fault_d;
        end
    end

    // Address FIFO pairs each returning beat with the PC it was fetched from.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            af_wp_q <= '0;
            af_rp_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                afifo_q[i] <= '0;
            end
        end else begin
            if (w_ar_hs) begin
                afifo_q[af_wp_q] <= w_araddr;
                af_wp_q          <= af_wp_q + AW'(1);
            end
            if (w_r_hs) begin
                af_rp_q <= af_rp_q + AW'(1);
            end
        end
    end

    // Output buffer storage; pointers are managed with the control registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                obuf_q[i] <= '0;
            end
        end else if (w_push) begin
            obuf_q[ob_wp_q] <= w_entry;
        end
    end

    assign fi.araddr  = w_araddr;
    assign fi.arvalid = w_arvalid;
    assign fi.rready  = run_q;
    assign fi.tdata   = obuf_q[ob_rp_q];
    assign fi.tvalid  = (occ_q != '0);
    assign fi.fault   = fault_q;
endmodule
`default_nettype wire
